// File: rtl/mannix_mem_pkg.sv
// Shared constants, responder state encoding and line/word helpers for the
// mannix memory-side blocks (responder and farm).
package mannix_mem_pkg;

  localparam int LINE_BYTES = 32;
  localparam int WORD_BYTES = 4;
  localparam int SIZE_W     = 6;
  localparam int LINE_W     = 8 * LINE_BYTES;
  localparam int WORD_W     = 8 * WORD_BYTES;
  localparam int LINE_WORDS = LINE_BYTES / WORD_BYTES;
  localparam int CNT_W      = 4;
  localparam int IDX_W      = 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_RD_DRAIN = 3'd2,
    S_RD_RESP  = 3'd3,
    S_WR       = 3'd4,
    S_ERR      = 3'd5
  } resp_state_e;

  // Only meaningful for legal sizes; illegal ones never reach the word loop.
  function automatic logic [CNT_W-1:0] word_count(input logic [SIZE_W-1:0] size);
    logic [SIZE_W:0] s;
    s = {1'b0, size} + (SIZE_W+1)'(WORD_BYTES - 1);
    return CNT_W'(s >> 2);
  endfunction

  function automatic logic size_legal(input logic [SIZE_W-1:0] size);
    return (size != '0) && (size <= SIZE_W'(LINE_BYTES));
  endfunction

  function automatic logic [WORD_BYTES-1:0] last_be(input logic [SIZE_W-1:0] size);
    logic [1:0] r;
    r = size[1:0];
    if (r == 2'd0) return '1;
    return (4'b0001 << r) - 4'b0001;
  endfunction

endpackage

// File: rtl/mannix_mem_responder_if.sv
// Client read/write request bus between a mannix engine and the memory responder.
// Handshake: the client raises req with addr/size(/data) and holds them stable
// until the one-cycle gnt pulse; the responder later returns exactly one
// one-cycle valid/done pulse per grant, with err qualifying that pulse.
interface mannix_mem_client_if #(parameter int ADDR_WIDTH = 19);
  import mannix_mem_pkg::*;

  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [SIZE_W-1:0]     rd_size;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [LINE_W-1:0]     rd_data;
  logic                  rd_err;

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [SIZE_W-1:0]     wr_size;
  logic [LINE_W-1:0]     wr_data;
  logic                  wr_gnt;
  logic                  wr_done;
  logic                  wr_err;

  modport master (
    output rd_req, rd_addr, rd_size,
    input  rd_gnt, rd_valid, rd_data, rd_err,
    output wr_req, wr_addr, wr_size, wr_data,
    input  wr_gnt, wr_done, wr_err
  );

  modport slave (
    input  rd_req, rd_addr, rd_size,
    output rd_gnt, rd_valid, rd_data, rd_err,
    input  wr_req, wr_addr, wr_size, wr_data,
    output wr_gnt, wr_done, wr_err
  );

endinterface

// File: rtl/mannix_mem_responder.sv
// Serves one client line request at a time by walking it word-by-word over a
// single-port synchronous SRAM; read words are packed back into a line.
module mannix_mem_responder
  import mannix_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mannix_mem_client_if.slave    bus,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [3:0]            sram_be,
  output logic [ADDR_WIDTH-3:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata,
  output logic                  busy,
  output resp_state_e           state_dbg
);

  resp_state_e           state_q, state_d;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [SIZE_W-1:0]     size_q;
  logic [LINE_W-1:0]     wdata_q;
  logic [LINE_W-1:0]     line_q;
  logic [CNT_W-1:0]      nwords_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  cap_vld_q;
  logic [IDX_W-1:0]      cap_idx_q;
  logic                  last_wr_q;
  logic                  err_is_rd_q;
  logic                  rd_gnt_q, wr_gnt_q;
  logic                  rd_valid_q, rd_err_q;
  logic                  wr_done_q, wr_err_q;

  logic                  pick_rd, pick_wr;
  logic                  last_word;
  logic [ADDR_WIDTH-3:0] word_addr;
  logic [WORD_W-1:0]     cap_word;

  assign last_word = (cnt_q == nwords_q - 4'd1);
  assign word_addr = addr_q + {{(ADDR_WIDTH-2-CNT_W){1'b0}}, cnt_q};

  always_comb begin
    state_d = state_q;
    pick_rd = 1'b0;
    pick_wr = 1'b0;
    case (state_q)
      S_IDLE: begin
        // On a tie the side not served last wins; last_wr_q resets high.
        pick_rd = bus.rd_req && (!bus.wr_req || last_wr_q);
        pick_wr = bus.wr_req && !pick_rd;
        if (pick_rd)      state_d = size_legal(bus.rd_size) ? S_RD : S_ERR;
        else if (pick_wr) state_d = size_legal(bus.wr_size) ? S_WR : S_ERR;
      end
      S_RD:       if (last_word) state_d = S_RD_DRAIN;
      S_RD_DRAIN: state_d = S_RD_RESP;
      S_RD_RESP:  state_d = S_IDLE;
      S_WR:       if (last_word) state_d = S_IDLE;
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (state_q == S_RD) begin
      sram_ce   = 1'b1;
      sram_addr = word_addr;
    end else if (state_q == S_WR) begin
      sram_ce    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = word_addr;
      sram_be    = last_word ? last_be(size_q) : 4'b1111;
      sram_wdata = wdata_q[WORD_W*cnt_q[IDX_W-1:0] +: WORD_W];
    end
  end

  // Bytes at or beyond the requested size are zeroed as the word is captured.
  always_comb begin
    cap_word = sram_rdata;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if ({1'b0, cap_idx_q, 2'(b)} >= size_q) cap_word[8*b +: 8] = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      line_q      <= '0;
      nwords_q    <= '0;
      cnt_q       <= '0;
      cap_vld_q   <= 1'b0;
      cap_idx_q   <= '0;
      last_wr_q   <= 1'b1;
      err_is_rd_q <= 1'b0;
      rd_gnt_q    <= 1'b0;
      wr_gnt_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      wr_done_q   <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_gnt_q   <= pick_rd;
      wr_gnt_q   <= pick_wr;
      rd_valid_q <= (state_q == S_RD_DRAIN) || (state_q == S_ERR && err_is_rd_q);
      rd_err_q   <= (state_q == S_ERR) && err_is_rd_q;
      wr_done_q  <= (state_q == S_WR && last_word) || (state_q == S_ERR && !err_is_rd_q);
      wr_err_q   <= (state_q == S_ERR) && !err_is_rd_q;

      // Read data lags its issue cycle by one, so capture trails the counter.
      cap_vld_q <= (state_q == S_RD);
      cap_idx_q <= cnt_q[IDX_W-1:0];
      if (cap_vld_q) line_q[WORD_W*cap_idx_q +: WORD_W] <= cap_word;

      if (state_q == S_RD || state_q == S_WR) cnt_q <= cnt_q + 4'd1;

      if (pick_rd) begin
        last_wr_q   <= 1'b0;
        err_is_rd_q <= 1'b1;
        line_q      <= '0;
        addr_q      <= bus.rd_addr[ADDR_WIDTH-1:2];
        size_q      <= bus.rd_size;
        nwords_q    <= word_count(bus.rd_size);
        cnt_q       <= '0;
      end else if (pick_wr) begin
        last_wr_q   <= 1'b1;
        err_is_rd_q <= 1'b0;
        addr_q      <= bus.wr_addr[ADDR_WIDTH-1:2];
        size_q      <= bus.wr_size;
        wdata_q     <= bus.wr_data;
        nwords_q    <= word_count(bus.wr_size);
        cnt_q       <= '0;
      end
    end
  end

  assign bus.rd_gnt   = rd_gnt_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.rd_data  = line_q;
  assign bus.wr_gnt   = wr_gnt_q;
  assign bus.wr_done  = wr_done_q;
  assign bus.wr_err   = wr_err_q;
  assign busy         = (state_q != S_IDLE);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_mannix_mem_responder.sv
// Bench for mannix_mem_responder: SRAM model, per-scenario tasks with inline
// timing checks, and a response scoreboard fed at grant time.
module tb_mannix_mem_responder;
  import mannix_mem_pkg::*;

  localparam int AW = 19;
  localparam int LW = LINE_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mannix_mem_client_if #(.ADDR_WIDTH(AW)) bus ();

  logic          sram_ce, sram_we;
  logic [3:0]    sram_be;
  logic [AW-3:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;
  logic          busy;
  resp_state_e   state_dbg;

  mannix_mem_responder #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // SRAM model: sparse word store, one-cycle read latency, byte-enabled writes.
  logic [31:0] mem [int];
  logic [31:0] mem_w;
  always @(posedge clk) begin
    if (sram_ce) begin
      mem_w = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 32'h0;
      if (sram_we) begin
        for (int b = 0; b < 4; b++) if (sram_be[b]) mem_w[8*b +: 8] = sram_wdata[8*b +: 8];
        mem[int'(sram_addr)] = mem_w;
      end else begin
        sram_rdata <= mem_w;
      end
    end
  end

  logic [LW:0] rd_exp_q [$];
  logic        wr_exp_q [$];
  logic [LW:0] rd_e;
  logic        wr_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_valid) begin
        checks++;
        if (rd_exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: rd_valid with nothing expected, rd_err=%0b", bus.rd_err);
        end else begin
          rd_e = rd_exp_q.pop_front();
          if ({bus.rd_err, bus.rd_data} !== rd_e) begin
            errors++;
            $display("FAIL rd_resp: got err=%0b data=%h want err=%0b data=%h",
                     bus.rd_err, bus.rd_data, rd_e[LW], rd_e[LW-1:0]);
          end
        end
      end
      if (bus.wr_done) begin
        checks++;
        if (wr_exp_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: wr_done with nothing expected, wr_err=%0b", bus.wr_err);
        end else begin
          wr_e = wr_exp_q.pop_front();
          if (bus.wr_err !== wr_e) begin
            errors++;
            $display("FAIL wr_resp: got err=%0b want err=%0b", bus.wr_err, wr_e);
          end
        end
      end
      checks++;
      if ((bus.rd_gnt && bus.wr_gnt) || (bus.rd_valid && bus.wr_done)) begin
        errors++;
        $display("FAIL exclusive: gnt=%0b%0b resp=%0b%0b want not both",
                 bus.rd_gnt, bus.wr_gnt, bus.rd_valid, bus.wr_done);
      end
      checks++;
      if (sram_ce && !(state_dbg inside {S_RD, S_WR})) begin
        errors++;
        $display("FAIL ce_state: sram_ce=1 in state %s want 0", state_dbg.name());
      end
    end
  end

  task automatic do_read(input logic [AW-1:0] a, input logic [5:0] sz,
                         input logic [LW-1:0] exp_line, input string name);
    int n;
    logic legal, got;
    logic [AW-3:0] wa;
    n = (int'(sz) + 3) / 4;
    legal = (sz != 0) && (sz <= 32);
    rd_exp_q.push_back(legal ? {1'b0, exp_line} : {1'b1, {LW{1'b0}}});
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = a; bus.rd_size = sz;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = bus.rd_gnt;
    end
    bus.rd_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_gnt: rd_gnt=0 want 1 within 20 cycles", name);
      return;
    end
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        wa = a[AW-1:2] + (AW-2)'(i);
        checks++;
        if (sram_ce !== 1'b1 || sram_we !== 1'b0 || sram_addr !== wa) begin
          errors++;
          $display("FAIL %s_word%0d: ce=%0b we=%0b addr=%h want ce=1 we=0 addr=%h",
                   name, i, sram_ce, sram_we, sram_addr, wa);
        end
      end
      @(negedge clk);
      checks++;
      if (bus.rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_early: rd_valid=%0b at c+N want 0", name, bus.rd_valid);
      end
    end else begin
      checks++;
      if (sram_ce !== 1'b0) begin
        errors++;
        $display("FAIL %s_noce: sram_ce=%0b want 0", name, sram_ce);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_err !== !legal || sram_ce !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid: rd_valid=%0b rd_err=%0b ce=%0b want 1 %0b 0",
               name, bus.rd_valid, bus.rd_err, sram_ce, !legal);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [5:0] sz,
                          input logic [LW-1:0] d, input string name);
    int n;
    logic legal, got;
    logic [AW-3:0] wa;
    logic [3:0] ebe;
    n = (int'(sz) + 3) / 4;
    legal = (sz != 0) && (sz <= 32);
    wr_exp_q.push_back(!legal);
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_size = sz; bus.wr_data = d;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = bus.wr_gnt;
    end
    bus.wr_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_gnt: wr_gnt=0 want 1 within 20 cycles", name);
      return;
    end
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        wa = a[AW-1:2] + (AW-2)'(i);
        ebe = (i == n - 1 && sz[1:0] != 2'd0) ? 4'((1 << sz[1:0]) - 1) : 4'b1111;
        checks++;
        if (sram_ce !== 1'b1 || sram_we !== 1'b1 || sram_addr !== wa ||
            sram_be !== ebe || sram_wdata !== d[32*i +: 32]) begin
          errors++;
          $display("FAIL %s_word%0d: ce=%0b we=%0b addr=%h be=%b wd=%h want 1 1 %h %b %h",
                   name, i, sram_ce, sram_we, sram_addr, sram_be, sram_wdata,
                   wa, ebe, d[32*i +: 32]);
        end
      end
    end else begin
      checks++;
      if (sram_ce !== 1'b0) begin
        errors++;
        $display("FAIL %s_noce: sram_ce=%0b want 0", name, sram_ce);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.wr_done !== 1'b1 || bus.wr_err !== !legal || sram_ce !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: wr_done=%0b wr_err=%0b ce=%0b want 1 %0b 0",
               name, bus.wr_done, bus.wr_err, sram_ce, !legal);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (sram_ce !== 1'b0 || sram_we !== 1'b0 || sram_be !== 4'h0 || sram_addr !== '0 ||
        sram_wdata !== 32'h0 || busy !== 1'b0 || state_dbg !== S_IDLE ||
        bus.rd_gnt !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_err !== 1'b0 ||
        bus.rd_data !== '0 || bus.wr_gnt !== 1'b0 || bus.wr_done !== 1'b0 ||
        bus.wr_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: ce=%0b we=%0b be=%h addr=%h busy=%0b st=%s gnt=%0b%0b resp=%0b%0b err=%0b%0b rd_data_nz=%0b want all 0/IDLE",
               name, sram_ce, sram_we, sram_be, sram_addr, busy, state_dbg.name(),
               bus.rd_gnt, bus.wr_gnt, bus.rd_valid, bus.wr_done, bus.rd_err,
               bus.wr_err, |bus.rd_data);
    end
  endtask

  task automatic wait_drained(input string name);
    for (int t = 0; t < 20 && (rd_exp_q.size() + wr_exp_q.size()) != 0; t++) @(negedge clk);
    checks++;
    if ((rd_exp_q.size() + wr_exp_q.size()) != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d responses outstanding want 0",
               name, rd_exp_q.size() + wr_exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_release");
  endtask

  task automatic test_arbitration();
    string seq;
    int grants;
    seq = "";
    grants = 0;
    bus.rd_req = 1'b1; bus.rd_addr = 19'h100; bus.rd_size = 6'd4;
    bus.wr_req = 1'b1; bus.wr_addr = 19'h500; bus.wr_size = 6'd4; bus.wr_data = 256'hDEADBEEF;
    for (int t = 0; t < 100 && grants < 3; t++) begin
      @(negedge clk);
      if (bus.rd_gnt || bus.wr_gnt) begin
        checks++;
        if (rd_exp_q.size() != 0 || wr_exp_q.size() != 0) begin
          errors++;
          $display("FAIL arb_overlap: grant with %0d responses pending want 0",
                   rd_exp_q.size() + wr_exp_q.size());
        end
        if (bus.rd_gnt) begin
          seq = {seq, "R"};
          rd_exp_q.push_back({1'b0, 256'hA0});
        end else begin
          seq = {seq, "W"};
          wr_exp_q.push_back(1'b0);
        end
        grants++;
        if (grants == 3) begin
          bus.rd_req = 1'b0;
          bus.wr_req = 1'b0;
        end
      end
    end
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    checks++;
    if (seq != "RWR") begin
      errors++;
      $display("FAIL arb_order: grants %s want RWR", seq);
    end
    wait_drained("arb");
  endtask

  task automatic test_read();
    logic [LW-1:0] full;
    full = '0;
    for (int k = 0; k < 8; k++) full[32*k +: 32] = 32'hA0 + 32'(k);
    do_read(19'h100, 6'd32, full, "read32");
    do_read(19'h100, 6'd5, {224'h0, 32'h000000A1, 32'h000000A0}, "read5_mask");
    do_read(19'h103, 6'd3, {224'h0, 32'h00A0A0A0 & 32'h00FFFFFF & 32'h000000A0 | 32'h0}, "read3_lowbits");
    wait_drained("read");
  endtask

  task automatic test_write();
    do_write(19'h20, 6'd6, 256'h060504030201, "write6");
    do_read(19'h20, 6'd8, {192'h0, 32'h00000605, 32'h04030201}, "readback");
    do_write(19'h600, 6'd32, {8{32'h5A5A_0000 + 32'h1}}, "write32");
    wait_drained("write");
  endtask

  task automatic test_illegal();
    do_read(19'h100, 6'd0, '0, "rd_size0");
    do_write(19'h100, 6'd33, {8{32'hFFFF_FFFF}}, "wr_size33");
    wait_drained("illegal");
  endtask

  task automatic test_wrap();
    do_read(19'h7FFFC, 6'd8, {192'h0, 32'h55667788, 32'h11223344}, "wrap");
    wait_drained("wrap");
  endtask

  task automatic test_reset_mid();
    logic got;
    logic [LW-1:0] full;
    full = '0;
    for (int k = 0; k < 8; k++) full[32*k +: 32] = 32'hA0 + 32'(k);
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = 19'h100; bus.rd_size = 6'd32;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = bus.rd_gnt;
    end
    bus.rd_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rstmid_gnt: rd_gnt=0 want 1 within 20 cycles");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sram_ce !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_active: sram_ce=%0b at c+3 want 1", sram_ce);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("rstmid_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    do_read(19'h100, 6'd32, full, "post_reset_read");
    wait_drained("rstmid");
  endtask

  initial begin
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_size = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_size = '0; bus.wr_data = '0;
    for (int k = 0; k < 8; k++) mem[32'h40 + k] = 32'hA0 + 32'(k);
    mem[32'h1FFFF] = 32'h11223344;
    mem[0]         = 32'h55667788;
    test_reset();
    test_arbitration();
    test_read();
    test_write();
    test_illegal();
    test_wrap();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
